hit_cnt_sb: RTL and testbench
=============================

# hit_cnt_sb

Parametrised per-triangle hit-count scoreboard for the raster back end. It queues golden per-triangle sample counts from the reference model ahead of the pipe and counts valid hits at stage R18 per triangle tag. When a triangle-done marker arrives it checks tag, count and tolerance, then posts a one-cycle verdict. It keeps running totals and a sticky error. Several triangles can be queued ahead of the pipe, and overflow and mis-ordering are caught in hardware.

## Interface
- SIGFIG, 24, bit width of the triangle/sample datapath (carried for pass-through bookkeeping only)
- TAG_W, 8, triangle tag width
- CNT_W, 16, hit counter width
- FIFO_DEPTH, 8, expected-count queue entries (power of two, ≥2)
- TOL, 0, allowed |observed − expected| (0 = exact mode)
- clk  in  1  clock
- rst  in  1  reset; one clock; reset is asynchronous and active-high
- exp_valid  in  1  golden entry offered
- exp_ready  out  1  queue can accept
- exp_tag  in  TAG_W  golden triangle tag
- exp_cnt  in  CNT_W  golden hit count
- hit_valid_R18H  in  1  valid hit this cycle
- hit_tag_R18H  in  TAG_W  tag of triangle producing hit
- tri_done_R18H  in  1  last cycle of triangle (may coincide with a hit)
- done_tag_R18H  in  TAG_W  tag of finishing triangle
- chk_valid  out  1  verdict pulse
- chk_pass  out  1  verdict passed
- chk_tag  out  TAG_W  tag checked
- chk_cnt  out  CNT_W  observed count
- chk_err  out  4  {overflow, stray_hit, tag_mismatch, underflow}
- err_sticky  out  1  any failure since reset
- num_checked  out  32  verdicts issued
- num_failed  out  32  failing verdicts
- fifo_level  out  $clog2(FIFO_DEPTH)+1  queued entries

## Operation
- FIFO: push on exp_valid && exp_ready. exp_ready = (fifo_level != FIFO_DEPTH), taken from the registered level. A pop in the same cycle does not raise exp_ready. Pointers wrap modulo FIFO_DEPTH.
- Accumulator acc (CNT_W):
  - On hit_valid_R18H && !tri_done_R18H: acc += 1.
  - Saturates at 2^CNT_W−1 and sets pending ovf.
- Stray hit: a hit with FIFO non-empty and hit_tag_R18H ≠ head tag sets pending stray. The hit is still counted.
- On tri_done_R18H:
  - final = acc + hit_valid_R18H, saturating, with ovf set if saturation occurs.
  - If FIFO empty: underflow=1. Compare against exp_cnt=0 and tag_mismatch=0, no pop.
  - Else: pop head. tag_mismatch = (done_tag ≠ head tag). Count ok = |final − head cnt| ≤ TOL, compared unsigned with no wrap.
  - pass = count ok && no error bits.
  - acc, pending ovf and pending stray clear to 0.
- States:
  - IDLE: acc==0 and no pending flags.
  - COUNT: a hit has been seen. IDLE→COUNT on the first hit.
  - REPORT: one cycle in which the verdict registers are valid. COUNT/IDLE→REPORT on done.
  - REPORT→COUNT if a hit arrives during REPORT, else →IDLE. A done during REPORT is processed normally, so back-to-back verdicts are allowed.
- Counters: num_checked +1 per verdict, num_failed +1 per failing verdict. Both wrap at 2^32.
- err_sticky: set on first failure, cleared only by rst.

## Timing
- Reset values: exp_ready=1, chk_valid=0, chk_pass=0, chk_tag=0, chk_cnt=0, chk_err=0, err_sticky=0, num_checked=0, num_failed=0, fifo_level=0, acc=0, state IDLE, pointers 0.
- Reset mid-operation discards queue and counts immediately. No verdict is issued for the open triangle.
- Verdict latency: chk_* are registered and valid exactly 1 cycle after the tri_done_R18H cycle. chk_valid is high for one cycle. chk_tag/cnt/err/pass hold until the next verdict.
- Push-to-pop: an entry pushed in cycle t is poppable at t+1. Push and done in the same cycle with the FIFO empty give underflow.
- Push and pop in the same cycle: fifo_level unchanged. Level updates one cycle after the push/pop.
- Counters and err_sticky update in the same cycle chk_valid rises.

## Test plan
- Exact pass: push (tag 5, cnt 3); hits at t1,t2,t3; done at t4 → chk_valid at t5, pass=1, chk_cnt=3, chk_err=0, num_checked=1.
- Hit on done cycle: push (7, 2); hit t1; hit+done t2 → chk_cnt=2, pass=1; the next triangle starts with acc=0.
- Mismatch and tolerance:
  - TOL=0: push (1, 4), 5 hits, done → pass=0, num_failed=1, err_sticky=1.
  - Rerun with TOL=1 → pass=1.
- Underflow and tag error:
  - Done with empty FIFO → chk_err=0001, pass=0.
  - Push (2, 1); done_tag 3 → chk_err=0010.
  - Hit with tag 9 while head tag is 2 → stray bit (0100) set.
- FIFO full/wrap: push FIFO_DEPTH entries → exp_ready=0, fifo_level=8. Pop one → exp_ready=1 next cycle. Push 20 entries total over time → verdict tags in order.
- Saturation and reset: CNT_W=4, 17 hits → chk_cnt=15, overflow bit set. Assert rst mid-triangle → all outputs at reset values the same cycle, and no chk_valid afterward.

Source files
------------

// File: rtl/hit_cnt_sb.sv
// hit_cnt_sb: per-triangle hit-count scoreboard checking observed hits against a queue of expected counts
module hit_cnt_sb #(
  parameter int SIGFIG     = 24,
  parameter int TAG_W      = 8,
  parameter int CNT_W      = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int TOL        = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          exp_valid,
  output logic                          exp_ready,
  input  logic [TAG_W-1:0]              exp_tag,
  input  logic [CNT_W-1:0]              exp_cnt,
  input  logic                          hit_valid_R18H,
  input  logic [TAG_W-1:0]              hit_tag_R18H,
  input  logic                          tri_done_R18H,
  input  logic [TAG_W-1:0]              done_tag_R18H,
  output logic                          chk_valid,
  output logic                          chk_pass,
  output logic [TAG_W-1:0]              chk_tag,
  output logic [CNT_W-1:0]              chk_cnt,
  output logic [3:0]                    chk_err,
  output logic                          err_sticky,
  output logic [31:0]                   num_checked,
  output logic [31:0]                   num_failed,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam logic [1:0] IDLE = 2'd0, COUNT = 2'd1, REPORT = 2'd2;
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || SIGFIG < 1) begin : g_bad_param
    $error("hit_cnt_sb: FIFO_DEPTH must be a power of two >= 2");
  end
  logic [TAG_W-1:0] mem_tag [FIFO_DEPTH];
  logic [CNT_W-1:0] mem_cnt [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [1:0]       state;
  logic [CNT_W-1:0] acc, fin, exp_c, diff;
  logic             pend_ovf, pend_stray, empty, push, pop, ovf_now, stray_now, pass;
  logic [TAG_W-1:0] head_tag;
  logic [3:0]       err;
  always_comb begin
    empty     = fifo_level == '0;
    exp_ready = fifo_level != LW'(FIFO_DEPTH);
    push      = exp_valid && exp_ready;
    pop       = tri_done_R18H && !empty;
    head_tag  = mem_tag[rd_ptr];
    // fin doubles as the next accumulator value and the final count on done
    fin       = (hit_valid_R18H && acc != '1) ? acc + 1'b1 : acc;
    ovf_now   = pend_ovf | (hit_valid_R18H && acc == '1);
    stray_now = pend_stray | (hit_valid_R18H && !empty && hit_tag_R18H != head_tag);
    exp_c     = empty ? '0 : mem_cnt[rd_ptr];
    diff      = fin >= exp_c ? fin - exp_c : exp_c - fin;
    err       = {ovf_now, stray_now, !empty && done_tag_R18H != head_tag, empty};
    pass      = diff <= CNT_W'(TOL) && err == 4'b0;
    chk_valid = state == REPORT;
  end
  always_ff @(posedge clk) begin
    if (push) begin
      mem_tag[wr_ptr] <= exp_tag;
      mem_cnt[wr_ptr] <= exp_cnt;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fifo_level  <= '0;
      state       <= IDLE;
      acc         <= '0;
      pend_ovf    <= 1'b0;
      pend_stray  <= 1'b0;
      chk_pass    <= 1'b0;
      chk_tag     <= '0;
      chk_cnt     <= '0;
      chk_err     <= '0;
      err_sticky  <= 1'b0;
      num_checked <= '0;
      num_failed  <= '0;
    end else begin
      wr_ptr     <= wr_ptr + AW'(push);
      rd_ptr     <= rd_ptr + AW'(pop);
      fifo_level <= fifo_level + LW'(push) - LW'(pop);
      state      <= tri_done_R18H ? REPORT : hit_valid_R18H ? COUNT : state == REPORT ? IDLE : state;
      acc        <= tri_done_R18H ? '0 : fin;
      pend_ovf   <= !tri_done_R18H && ovf_now;
      pend_stray <= !tri_done_R18H && stray_now;
      if (tri_done_R18H) begin
        chk_pass    <= pass;
        chk_tag     <= done_tag_R18H;
        chk_cnt     <= fin;
        chk_err     <= err;
        err_sticky  <= err_sticky | !pass;
        num_checked <= num_checked + 1;
        num_failed  <= num_failed + 32'(!pass);
      end
    end
  end
endmodule

// File: tb/tb_hit_cnt_sb.sv
// tb_hit_cnt_sb: directed self-checking bench for hit_cnt_sb (exact, tolerant and narrow-counter builds)
module tb_hit_cnt_sb;
  logic        clk = 1'b0, rst = 1'b1;
  logic        exp_valid = 1'b0, hit_valid = 1'b0, tri_done = 1'b0;
  logic [7:0]  exp_tag = '0, hit_tag = '0, done_tag = '0;
  logic [15:0] exp_cnt = '0;
  int          n_chk = 0, n_fail = 0;

  logic        rdy0, v0, p0, es0;
  logic [7:0]  t0;
  logic [15:0] c0;
  logic [3:0]  e0, l0;
  logic [31:0] nc0, nf0;
  logic        rdy1, v1, p1, es1;
  logic [7:0]  t1;
  logic [15:0] c1;
  logic [3:0]  e1, l1;
  logic [31:0] nc1, nf1;
  logic        rdy2, v2, p2, es2;
  logic [7:0]  t2;
  logic [3:0]  c2, e2, l2;
  logic [31:0] nc2, nf2;

  hit_cnt_sb u0 (.clk(clk), .rst(rst), .exp_valid(exp_valid), .exp_ready(rdy0), .exp_tag(exp_tag),
    .exp_cnt(exp_cnt), .hit_valid_R18H(hit_valid), .hit_tag_R18H(hit_tag), .tri_done_R18H(tri_done),
    .done_tag_R18H(done_tag), .chk_valid(v0), .chk_pass(p0), .chk_tag(t0), .chk_cnt(c0), .chk_err(e0),
    .err_sticky(es0), .num_checked(nc0), .num_failed(nf0), .fifo_level(l0));
  hit_cnt_sb #(.TOL(1)) u1 (.clk(clk), .rst(rst), .exp_valid(exp_valid), .exp_ready(rdy1), .exp_tag(exp_tag),
    .exp_cnt(exp_cnt), .hit_valid_R18H(hit_valid), .hit_tag_R18H(hit_tag), .tri_done_R18H(tri_done),
    .done_tag_R18H(done_tag), .chk_valid(v1), .chk_pass(p1), .chk_tag(t1), .chk_cnt(c1), .chk_err(e1),
    .err_sticky(es1), .num_checked(nc1), .num_failed(nf1), .fifo_level(l1));
  hit_cnt_sb #(.CNT_W(4)) u2 (.clk(clk), .rst(rst), .exp_valid(exp_valid), .exp_ready(rdy2), .exp_tag(exp_tag),
    .exp_cnt(exp_cnt[3:0]), .hit_valid_R18H(hit_valid), .hit_tag_R18H(hit_tag), .tri_done_R18H(tri_done),
    .done_tag_R18H(done_tag), .chk_valid(v2), .chk_pass(p2), .chk_tag(t2), .chk_cnt(c2), .chk_err(e2),
    .err_sticky(es2), .num_checked(nc2), .num_failed(nf2), .fifo_level(l2));

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] tg, input logic [15:0] cn);
    exp_valid = 1'b1; exp_tag = tg; exp_cnt = cn;
    tick;
    exp_valid = 1'b0;
  endtask

  task automatic hits(input int n, input logic [7:0] tg);
    for (int i = 0; i < n; i++) begin
      hit_valid = 1'b1; hit_tag = tg;
      tick;
    end
    hit_valid = 1'b0;
  endtask

  task automatic done(input logic [7:0] tg, input logic hv);
    tri_done = 1'b1; done_tag = tg; hit_valid = hv; hit_tag = tg;
    tick;
    tri_done = 1'b0; hit_valid = 1'b0;
  endtask

  initial begin
    tick; tick;
    chk("rst_ready", rdy0, 1); chk("rst_valid", v0, 0); chk("rst_pass", p0, 0);
    chk("rst_tag", t0, 0); chk("rst_cnt", c0, 0); chk("rst_err", e0, 0);
    chk("rst_sticky", es0, 0); chk("rst_checked", nc0, 0); chk("rst_failed", nf0, 0);
    chk("rst_level", l0, 0);
    rst = 1'b0;
    tick;
    // exact pass
    push(8'd5, 16'd3);
    chk("push_level", l0, 1);
    hits(3, 8'd5);
    chk("no_early_valid", v0, 0);
    done(8'd5, 1'b0);
    chk("exact_valid", v0, 1); chk("exact_pass", p0, 1); chk("exact_cnt", c0, 3);
    chk("exact_err", e0, 0); chk("exact_tag", t0, 5); chk("exact_checked", nc0, 1);
    chk("exact_level", l0, 0);
    tick;
    chk("valid_pulse", v0, 0); chk("cnt_hold", c0, 3);
    // hit on done cycle
    push(8'd7, 16'd2);
    hits(1, 8'd7);
    done(8'd7, 1'b1);
    chk("hod_cnt", c0, 2); chk("hod_pass", p0, 1); chk("hod_checked", nc0, 2);
    // mismatch, and tolerance on the TOL=1 build
    push(8'd1, 16'd4);
    hits(5, 8'd1);
    done(8'd1, 1'b0);
    chk("mis_pass", p0, 0); chk("mis_cnt", c0, 5); chk("mis_err", e0, 0);
    chk("mis_failed", nf0, 1); chk("mis_sticky", es0, 1); chk("tol_pass", p1, 1);
    // underflow
    done(8'd0, 1'b0);
    chk("unf_err", e0, 4'b0001); chk("unf_pass", p0, 0); chk("unf_cnt", c0, 0);
    // tag mismatch
    push(8'd2, 16'd1);
    hits(1, 8'd2);
    done(8'd3, 1'b0);
    chk("tag_err", e0, 4'b0010); chk("tag_pass", p0, 0); chk("tag_cnt", c0, 1);
    // stray hit
    push(8'd2, 16'd1);
    hits(1, 8'd9);
    done(8'd2, 1'b0);
    chk("stray_err", e0, 4'b0100); chk("stray_pass", p0, 0); chk("stray_cnt", c0, 1);
    chk("stray_checked", nc0, 6); chk("stray_failed", nf0, 4);
    // FIFO full, simultaneous push/pop, wrap and ordering
    for (int i = 0; i < 8; i++) push(8'(10 + i), 16'd0);
    chk("full_ready", rdy0, 0); chk("full_level", l0, 8);
    done(8'd10, 1'b0);
    chk("pop_ready", rdy0, 1); chk("pop_level", l0, 7); chk("pop_tag", t0, 10); chk("pop_pass", p0, 1);
    for (int i = 0; i < 12; i++) begin
      exp_valid = 1'b1; exp_tag = 8'(18 + i); exp_cnt = '0;
      tri_done = 1'b1; done_tag = 8'(11 + i);
      tick;
      chk("pp_tag", t0, 11 + i); chk("pp_pass", p0, 1); chk("pp_level", l0, 7); chk("pp_valid", v0, 1);
    end
    exp_valid = 1'b0; tri_done = 1'b0;
    for (int i = 0; i < 7; i++) begin
      done(8'(23 + i), 1'b0);
      chk("drain_tag", t0, 23 + i); chk("drain_pass", p0, 1);
    end
    chk("drain_level", l0, 0); chk("drain_checked", nc0, 26); chk("drain_failed", nf0, 4);
    // saturation on the 4-bit build
    push(8'd4, 16'd15);
    hits(17, 8'd4);
    done(8'd4, 1'b0);
    chk("sat_cnt", c2, 15); chk("sat_err", e2, 4'b1000); chk("sat_pass", p2, 0); chk("wide_cnt", c0, 17);
    // reset mid-triangle
    push(8'd6, 16'd2);
    hits(1, 8'd6);
    rst = 1'b1;
    #1;
    chk("mrst_ready", rdy0, 1); chk("mrst_level", l0, 0); chk("mrst_checked", nc0, 0);
    chk("mrst_failed", nf0, 0); chk("mrst_sticky", es0, 0); chk("mrst_tag", t0, 0);
    chk("mrst_cnt", c0, 0); chk("mrst_err", e0, 0); chk("mrst_pass", p0, 0); chk("mrst_valid", v0, 0);
    tick;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("post_rst_valid", v0, 0);
    end
    chk("post_rst_checked", nc0, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
